// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register plus EX-side forwarding muxes feeding the ALU.
// Define ID_EX_STALL_EN to add the StallE hold input.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            FlushE,
`ifdef ID_EX_STALL_EN
    input  logic            StallE,
`endif
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [REGW-1:0] Rs1D,
    input  logic [REGW-1:0] Rs2D,
    input  logic [REGW-1:0] RdD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            JumpD,
    input  logic            BranchD,
    input  logic            ALUSrcD,
    input  logic [1:0]      ResultSrcD,
    input  logic [3:0]      ALUControlD,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [3:0]      ALUControlE,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            JumpE,
    output logic            BranchE,
    output logic [1:0]      ResultSrcE,
    output logic [REGW-1:0] Rs1E,
    output logic [REGW-1:0] Rs2E,
    output logic [REGW-1:0] RdE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ImmExtE,
    output logic            ValidE
);
    typedef struct packed {
        logic [XLEN-1:0] rd1, rd2, pc, pc4, imm;
        logic [REGW-1:0] rs1, rs2, rd;
        logic            reg_write, mem_write, jump, branch, alu_src;
        logic [1:0]      result_src;
        logic [3:0]      alu_control;
        logic            valid;
    } stage_t;

    stage_t d, e;
    logic load;
    logic [XLEN-1:0] fwd_a, fwd_b;

    assign d = '{rd1: RD1D, rd2: RD2D, pc: PCD, pc4: PCPlus4D, imm: ImmExtD,
                 rs1: Rs1D, rs2: Rs2D, rd: RdD,
                 reg_write: RegWriteD, mem_write: MemWriteD, jump: JumpD,
                 branch: BranchD, alu_src: ALUSrcD, result_src: ResultSrcD,
                 alu_control: ALUControlD, valid: 1'b1};

`ifdef ID_EX_STALL_EN
    assign load = !StallE;
`else
    assign load = 1'b1;
`endif

    // Flush zeroes data fields too, so a bubble is fully deterministic
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            e <= '0;
        else if (FlushE)
            e <= '0;
        else if (load)
            e <= d;
    end

    // Select 11 is reserved and falls back to the registered operand
    assign fwd_a = (ForwardAE == 2'b01) ? ResultW : (ForwardAE == 2'b10) ? ALUResultM : e.rd1;
    assign fwd_b = (ForwardBE == 2'b01) ? ResultW : (ForwardBE == 2'b10) ? ALUResultM : e.rd2;

    assign SrcAE       = fwd_a;
    assign WriteDataE  = fwd_b;
    assign SrcBE       = e.alu_src ? e.imm : fwd_b;
    assign ALUControlE = e.alu_control;
    assign RegWriteE   = e.reg_write;
    assign MemWriteE   = e.mem_write;
    assign JumpE       = e.jump;
    assign BranchE     = e.branch;
    assign ResultSrcE  = e.result_src;
    assign Rs1E        = e.rs1;
    assign Rs2E        = e.rs2;
    assign RdE         = e.rd;
    assign PCE         = e.pc;
    assign PCPlus4E    = e.pc4;
    assign ImmExtE     = e.imm;
    assign ValidE      = e.valid;
endmodule
